// File: rtl/aw_channel_controller_if.sv
// AXI write-address / write-data bundle shared by the two upstream masters
// and the single downstream slave port of the AW channel controller.
//
// Handshake semantics: a beat transfers on a rising clock edge where valid
// and ready are both high. The source holds valid and its payload steady
// until that edge. The sink may raise or lower ready freely. Payload is
// meaningful only while valid is high.
interface aw_channel_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Write-address channel
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awqos;

  // Write-data channel
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  // The side that originates transactions
  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awqos,
    output wvalid, wdata, wstrb, wlast,
    input  awready, wready
  );

  // The side that accepts transactions
  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awqos,
    input  wvalid, wdata, wstrb, wlast,
    output awready, wready
  );
endinterface

// File: rtl/aw_channel_controller.sv
// AW/W routing stage behind the 2-master QoS write-address arbiter.
// Opens the arbiter's grant window, holds its selection while the chosen
// master's AW beat is forwarded, and records each accepted AW in a small
// FIFO so W bursts are steered to the slave in AW-acceptance order.
module aw_channel_controller #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int W_FIFO_DEPTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,

  // Arbiter side
  input  logic                          Channel_Request,
  input  logic                          Selected_Slave,
  output logic                          Channel_Granted,
  output logic                          Token,

  // Master-facing ports (S00 = master 0, S01 = master 1)
  aw_channel_controller_if.slave        S00_AXI,
  aw_channel_controller_if.slave        S01_AXI,

  // Slave-facing port
  aw_channel_controller_if.master       M_AXI,

  // Observability of the FSM and routing FIFO
  output logic [0:0]                    dbg_state_o,
  output logic [$clog2(W_FIFO_DEPTH):0] dbg_fifo_count_o
);

  localparam int PTR_W = $clog2(W_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(W_FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ADDR = 1'b1;

  // FSM and FIFO state
  logic [0:0]              state_q, state_d;
  logic [W_FIFO_DEPTH-1:0] fifo_mem_q, fifo_mem_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Decoded status and events
  logic                    in_idle;
  logic                    in_addr;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    grant;
  logic                    aw_fire;
  logic                    w_pop;
  logic                    head_sel;

  // Muxed payloads of the currently routed masters
  logic                    sel_awvalid;
  logic [ADDR_WIDTH-1:0]   sel_awaddr;
  logic                    head_wvalid;
  logic [DATA_WIDTH-1:0]   head_wdata;
  logic [DATA_WIDTH/8-1:0] head_wstrb;
  logic                    head_wlast;

  // Status decode: grant window and token depend on registered state only
  always_comb begin
    in_idle         = (state_q == ST_IDLE);
    in_addr         = (state_q == ST_ADDR);
    fifo_full       = (count_q == FIFO_FULL_CNT);
    fifo_empty      = (count_q == '0);
    Channel_Granted = in_idle && !fifo_full;
    Token           = in_addr;
    grant           = Channel_Granted && Channel_Request;
    head_sel        = fifo_mem_q[rd_ptr_q];
  end

  // AW path: forward the arbiter's chosen master while the token is held
  always_comb begin
    sel_awvalid      = Selected_Slave ? S01_AXI.awvalid : S00_AXI.awvalid;
    sel_awaddr       = Selected_Slave ? S01_AXI.awaddr  : S00_AXI.awaddr;
    M_AXI.awvalid    = in_addr && sel_awvalid;
    M_AXI.awaddr     = sel_awaddr;
    M_AXI.awlen      = Selected_Slave ? S01_AXI.awlen   : S00_AXI.awlen;
    M_AXI.awsize     = Selected_Slave ? S01_AXI.awsize  : S00_AXI.awsize;
    M_AXI.awburst    = Selected_Slave ? S01_AXI.awburst : S00_AXI.awburst;
    M_AXI.awqos      = Selected_Slave ? S01_AXI.awqos   : S00_AXI.awqos;
    S00_AXI.awready  = in_addr && !Selected_Slave && M_AXI.awready;
    S01_AXI.awready  = in_addr &&  Selected_Slave && M_AXI.awready;
    aw_fire          = in_addr && sel_awvalid && M_AXI.awready;
  end

  // W path: the FIFO head picks the master; an empty FIFO blocks both
  always_comb begin
    head_wvalid     = head_sel ? S01_AXI.wvalid : S00_AXI.wvalid;
    head_wdata      = head_sel ? S01_AXI.wdata  : S00_AXI.wdata;
    head_wstrb      = head_sel ? S01_AXI.wstrb  : S00_AXI.wstrb;
    head_wlast      = head_sel ? S01_AXI.wlast  : S00_AXI.wlast;
    M_AXI.wvalid    = !fifo_empty && head_wvalid;
    M_AXI.wdata     = head_wdata;
    M_AXI.wstrb     = head_wstrb;
    M_AXI.wlast     = head_wlast;
    S00_AXI.wready  = !fifo_empty && !head_sel && M_AXI.wready;
    S01_AXI.wready  = !fifo_empty &&  head_sel && M_AXI.wready;
    w_pop           = !fifo_empty && head_wvalid && M_AXI.wready && head_wlast;
  end

  // FSM next state: IDLE waits for a granted request, ADDR waits for the AW
  // handshake (no timeout if the selected master withdraws awvalid)
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant)   state_d = ST_ADDR;
      ST_ADDR: if (aw_fire) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // FIFO next state: push the AW winner, pop on the last W beat of a burst.
  // Fullness is checked at grant time, so a push never lands on a full FIFO.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (aw_fire) begin
      fifo_mem_d[wr_ptr_q] = Selected_Slave;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({aw_fire, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops any in-flight address or burst routing
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      fifo_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Debug view of the FSM and FIFO occupancy
  always_comb begin
    dbg_state_o      = state_q;
    dbg_fifo_count_o = count_q;
  end

endmodule

// File: tb/tb_aw_channel_controller.sv
// Directed-plus-random bench for aw_channel_controller. The bench plays the
// upstream QoS arbiter (higher awqos wins, ties go to S00) and predicts the
// forwarded AW and W streams with expectation queues.
module tb_aw_channel_controller;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  logic          Channel_Request;
  logic          Selected_Slave;
  logic          Channel_Granted;
  logic          Token;
  logic [0:0]    dbg_state;
  logic [CW-1:0] dbg_count;

  aw_channel_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0 ();
  aw_channel_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1 ();
  aw_channel_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m ();

  aw_channel_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .W_FIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK             (ACLK),
    .ARESETN          (ARESETN),
    .Channel_Request  (Channel_Request),
    .Selected_Slave   (Selected_Slave),
    .Channel_Granted  (Channel_Granted),
    .Token            (Token),
    .S00_AXI          (s0),
    .S01_AXI          (s1),
    .M_AXI            (m),
    .dbg_state_o      (dbg_state),
    .dbg_fifo_count_o (dbg_count)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [49:0] exp_aw_q[$];  // {master, addr, len, size, burst, qos}
  logic [37:0] exp_w_q[$];   // {master, wlast, wstrb, wdata}
  logic [49:0] mon_aw;
  logic [37:0] mon_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] beat_data(input bit mm, input logic [7:0] tag, input int b);
    return {(mm ? 8'hB1 : 8'hA0), tag, 8'h5A, 8'(b)};
  endfunction

  function automatic logic [3:0] beat_strb(input int b);
    return 4'(4'hF >> (b % 4));
  endfunction

  task automatic push_aw(input bit mm, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] q);
    exp_aw_q.push_back({mm, a, l, sz, bu, q});
  endtask

  task automatic push_w(input bit mm, input int nb, input logic [7:0] tag);
    for (int b = 0; b < nb; b++)
      exp_w_q.push_back({mm, 1'(b == nb - 1), beat_strb(b), beat_data(mm, tag, b)});
  endtask

  // ---------------- upstream arbiter emulation ----------------
  bit grant_seen;
  bit pick;
  initial begin
    Channel_Request = 1'b0;
    Selected_Slave  = 1'b0;
    forever begin
      @(negedge ACLK);
      Channel_Request = ARESETN && !Token && (s0.awvalid || s1.awvalid);
      grant_seen      = Channel_Request && Channel_Granted;
      pick            = s1.awvalid && (!s0.awvalid || (s1.awqos > s0.awqos));
      @(posedge ACLK);
      #1;
      if (grant_seen && ARESETN) Selected_Slave = pick;
    end
  end

  // ---------------- monitor: every slave-side handshake vs. expectation ----------------
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (m.awvalid && m.awready) begin
        chk("aw_expected", exp_aw_q.size() != 0, 1);
        if (exp_aw_q.size() != 0) begin
          mon_aw = exp_aw_q.pop_front();
          chk("aw_payload", {m.awaddr, m.awlen, m.awsize, m.awburst, m.awqos}, mon_aw[48:0]);
          chk("aw_route", {s1.awready, s0.awready}, mon_aw[49] ? 2'b10 : 2'b01);
        end
      end
      if (m.wvalid && m.wready) begin
        chk("w_expected", exp_w_q.size() != 0, 1);
        if (exp_w_q.size() != 0) begin
          mon_w = exp_w_q.pop_front();
          chk("w_beat", {m.wlast, m.wstrb, m.wdata}, mon_w[36:0]);
          chk("w_route", {s1.wready, s0.wready}, mon_w[37] ? 2'b10 : 2'b01);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_aw(input bit mm, input logic v, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] q);
    if (mm) begin
      s1.awvalid = v; s1.awaddr = a; s1.awlen = l; s1.awsize = sz; s1.awburst = bu; s1.awqos = q;
    end else begin
      s0.awvalid = v; s0.awaddr = a; s0.awlen = l; s0.awsize = sz; s0.awburst = bu; s0.awqos = q;
    end
  endtask

  task automatic set_w(input bit mm, input logic v, input logic [31:0] d, input logic [3:0] s,
                       input logic l);
    if (mm) begin
      s1.wvalid = v; s1.wdata = d; s1.wstrb = s; s1.wlast = l;
    end else begin
      s0.wvalid = v; s0.wdata = d; s0.wstrb = s; s0.wlast = l;
    end
  endtask

  // Present one AW on master mm until it is accepted; tok counts Token-high cycles
  task automatic send_aw(input bit mm, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] q,
                         output int tok);
    bit hs;
    tok = 0;
    hs  = 0;
    set_aw(mm, 1'b1, a, l, sz, bu, q);
    for (int c = 0; c < 300 && !hs; c++) begin
      @(negedge ACLK);
      if (Token) tok++;
      hs = mm ? (s1.awvalid && s1.awready) : (s0.awvalid && s0.awready);
      tick();
    end
    chk($sformatf("aw_accepted_m%0d", mm), hs, 1);
    if (mm) s1.awvalid = 1'b0; else s0.awvalid = 1'b0;
  endtask

  // Drive an nb-beat burst on master mm, each beat held until accepted
  task automatic send_w(input bit mm, input int nb, input logic [7:0] tag);
    bit hs;
    for (int b = 0; b < nb; b++) begin
      set_w(mm, 1'b1, beat_data(mm, tag, b), beat_strb(b), 1'(b == nb - 1));
      hs = 0;
      for (int c = 0; c < 300 && !hs; c++) begin
        @(negedge ACLK);
        hs = mm ? (s1.wvalid && s1.wready) : (s0.wvalid && s0.wready);
        tick();
      end
      chk($sformatf("w_accepted_m%0d_b%0d", mm, b), hs, 1);
    end
    set_w(mm, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_granted"}, Channel_Granted, 1);
    chk({tag, "_token"}, Token, 0);
    chk({tag, "_m_awvalid"}, m.awvalid, 0);
    chk({tag, "_m_wvalid"}, m.wvalid, 0);
    chk({tag, "_readies"}, {s1.awready, s0.awready, s1.wready, s0.wready}, 4'b0000);
    chk({tag, "_count"}, dbg_count, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int          tok, t0, t1;
  bit          fq[$];
  bit          mm, hs, tk, v0, v1, rnd_done;
  logic [31:0] a0, a1;
  logic [7:0]  l0, l1, tg;
  logic [3:0]  q0, q1;
  logic [1:0]  bu;

  initial begin
    ARESETN = 1'b0;
    set_aw(0, 1'b0, '0, '0, '0, '0, '0);
    set_aw(1, 1'b0, '0, '0, '0, '0, '0);
    set_w(0, 1'b0, '0, '0, 1'b0);
    set_w(1, 1'b0, '0, '0, 1'b0);
    m.awready = 1'b0;
    m.wready  = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    tick();
    chk("post_reset_granted", Channel_Granted, 1);

    // Single write: 0x1000, 4 beats
    m.awready = 1'b1;
    m.wready  = 1'b1;
    push_aw(0, 32'h1000, 8'd3, 3'd2, 2'b01, 4'd0);
    push_w(0, 4, 8'h01);
    send_aw(0, 32'h1000, 8'd3, 3'd2, 2'b01, 4'd0, tok);
    chk("single_token_cycles", tok, 1);
    chk("single_fifo_pushed", dbg_count, 1);
    chk("single_no_wvalid", m.wvalid, 0);
    send_w(0, 4, 8'h01);
    chk("single_fifo_empty", dbg_count, 0);

    // QoS contention: S01 (qos 9) beats S00 (qos 2) on AW and W order
    push_aw(1, 32'h2000, 8'd1, 3'd2, 2'b01, 4'd9);
    push_aw(0, 32'h3000, 8'd2, 3'd2, 2'b01, 4'd2);
    push_w(1, 2, 8'h02);
    push_w(0, 3, 8'h03);
    fork
      send_aw(0, 32'h3000, 8'd2, 3'd2, 2'b01, 4'd2, t0);
      send_aw(1, 32'h2000, 8'd1, 3'd2, 2'b01, 4'd9, t1);
      send_w(0, 3, 8'h03);
      send_w(1, 2, 8'h02);
    join
    chk("contention_fifo_empty", dbg_count, 0);

    // FIFO full: four single-beat AWs with W stalled
    m.wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mm = 1'($urandom_range(0, 1));
      q0 = 4'($urandom_range(0, 15));
      push_aw(mm, 32'h4000 + 32'(i * 16), 8'd0, 3'd2, 2'b01, q0);
      send_aw(mm, 32'h4000 + 32'(i * 16), 8'd0, 3'd2, 2'b01, q0, tok);
      fq.push_back(mm);
    end
    chk("full_granted_low", Channel_Granted, 0);
    chk("full_count", dbg_count, 4);
    push_aw(0, 32'h5000, 8'd0, 3'd2, 2'b01, 4'd1);
    set_aw(0, 1'b1, 32'h5000, 8'd0, 3'd2, 2'b01, 4'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("full_no_fifth_aw", {Token, m.awvalid}, 2'b00);
      tick();
    end
    mm = fq.pop_front();
    push_w(mm, 1, 8'h40);
    set_w(mm, 1'b1, beat_data(mm, 8'h40, 0), beat_strb(0), 1'b1);
    m.wready = 1'b1;
    @(negedge ACLK);
    chk("full_pop_handshake", mm ? s1.wready : s0.wready, 1);
    tick();
    m.wready = 1'b0;
    set_w(mm, 1'b0, '0, '0, 1'b0);
    chk("full_reopen_granted", Channel_Granted, 1);
    hs = 0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge ACLK);
      hs = s0.awvalid && s0.awready;
      tick();
    end
    chk("full_fifth_aw_accepted", hs, 1);
    s0.awvalid = 1'b0;
    fq.push_back(1'b0);
    m.wready = 1'b1;
    for (int i = 0; fq.size() != 0; i++) begin
      mm = fq.pop_front();
      tg = 8'(8'h41 + i);
      push_w(mm, 1, tg);
      send_w(mm, 1, tg);
    end
    chk("full_drained", dbg_count, 0);

    // W before AW: S01 W stalls until the cycle after its AW handshake
    push_w(1, 2, 8'h50);
    set_w(1, 1'b1, beat_data(1, 8'h50, 0), beat_strb(0), 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("wfirst_stalled", {s1.wready, m.wvalid}, 2'b00);
      tick();
    end
    push_aw(1, 32'h6000, 8'd1, 3'd2, 2'b01, 4'd3);
    set_aw(1, 1'b1, 32'h6000, 8'd1, 3'd2, 2'b01, 4'd3);
    hs = 0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge ACLK);
      chk("wfirst_wvalid_low", m.wvalid, 0);
      hs = s1.awvalid && s1.awready;
      tick();
    end
    chk("wfirst_aw_accepted", hs, 1);
    s1.awvalid = 1'b0;
    #1;
    chk("wfirst_open", {s1.wready, m.wvalid}, 2'b11);
    send_w(1, 2, 8'h50);

    // Slave backpressure on AW for 5 cycles
    m.awready = 1'b0;
    a0 = $urandom;
    q0 = 4'($urandom_range(0, 15));
    bu = 2'($urandom_range(0, 2));
    push_aw(0, a0, 8'd0, 3'd2, bu, q0);
    push_w(0, 1, 8'h60);
    set_aw(0, 1'b1, a0, 8'd0, 3'd2, bu, q0);
    tk = 0;
    for (int c = 0; c < 20 && !tk; c++) begin
      tick();
      tk = Token;
    end
    chk("bp_token_rise", tk, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      chk("bp_hold", {Token, m.awvalid, m.awaddr, m.awburst, m.awqos}, {1'b1, 1'b1, a0, bu, q0});
      chk("bp_awready_low", s0.awready, 0);
      tick();
    end
    m.awready = 1'b1;
    @(negedge ACLK);
    chk("bp_handshake", s0.awready, 1);
    tick();
    s0.awvalid = 1'b0;
    chk("bp_back_idle", {Token, dbg_state}, 2'b00);
    send_w(0, 1, 8'h60);

    // Reset during ADDR with two FIFO entries
    m.wready = 1'b0;
    push_aw(0, 32'h7000, 8'd0, 3'd2, 2'b01, 4'd4);
    send_aw(0, 32'h7000, 8'd0, 3'd2, 2'b01, 4'd4, tok);
    push_aw(1, 32'h7100, 8'd0, 3'd2, 2'b01, 4'd5);
    send_aw(1, 32'h7100, 8'd0, 3'd2, 2'b01, 4'd5, tok);
    m.awready = 1'b0;
    set_aw(0, 1'b1, 32'h7200, 8'd0, 3'd2, 2'b01, 4'd6);
    tk = 0;
    for (int c = 0; c < 20 && !tk; c++) begin
      tick();
      tk = Token;
    end
    chk("rst_in_addr", {tk, dbg_count}, {1'b1, CW'(2)});
    m.wready  = 1'b1;
    m.awready = 1'b1;
    #2;
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_aw_q.delete();
    exp_w_q.delete();
    s0.awvalid = 1'b0;
    tick();
    ARESETN = 1'b1;
    tick();
    chk("rst_release_granted", Channel_Granted, 1);
    chk("rst_release_count", dbg_count, 0);

    // Randomized traffic with random slave backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          v0 = 1'($urandom_range(0, 1));
          v1 = 1'($urandom_range(0, 1));
          if (!v0 && !v1) v0 = 1'b1;
          a0 = $urandom; a1 = $urandom;
          q0 = 4'($urandom_range(0, 15)); q1 = 4'($urandom_range(0, 15));
          l0 = 8'($urandom_range(0, 3));  l1 = 8'($urandom_range(0, 3));
          tg = 8'(8'h80 + i);
          // Higher QoS goes first; ties go to S00
          if (v0 && v1 && (q1 > q0)) begin
            push_aw(1, a1, l1, 3'd2, 2'b01, q1); push_w(1, int'(l1) + 1, tg);
            push_aw(0, a0, l0, 3'd2, 2'b01, q0); push_w(0, int'(l0) + 1, tg);
          end else begin
            if (v0) begin push_aw(0, a0, l0, 3'd2, 2'b01, q0); push_w(0, int'(l0) + 1, tg); end
            if (v1) begin push_aw(1, a1, l1, 3'd2, 2'b01, q1); push_w(1, int'(l1) + 1, tg); end
          end
          fork
            begin if (v0) send_aw(0, a0, l0, 3'd2, 2'b01, q0, t0); end
            begin if (v1) send_aw(1, a1, l1, 3'd2, 2'b01, q1, t1); end
            begin if (v0) send_w(0, int'(l0) + 1, tg); end
            begin if (v1) send_w(1, int'(l1) + 1, tg); end
          join
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          tick();
          m.wready  = 1'($urandom_range(0, 1));
          m.awready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m.wready  = 1'b1;
    m.awready = 1'b1;
    repeat (3) tick();
    chk("final_aw_queue_empty", exp_aw_q.size(), 0);
    chk("final_w_queue_empty", exp_w_q.size(), 0);
    chk("final_fifo_empty", dbg_count, 0);
    chk("final_idle", {dbg_state, Token, Channel_Granted}, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
